// File: rtl/beat_timing_pkg.sv
// Shared definitions for the beat/machine-cycle timing generator:
// controller state encoding, default geometry and index-width helper.
package beat_timing_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int BEATS_DEFAULT = 8;
    localparam int MCYC_DEFAULT  = 4;

    // Binary index width for an n-bit one-hot vector, never less than 1.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/beat_timing_gen_onehot_ring.sv
// One-hot ring counter with a binary index kept in lock-step.
// Used once for the beat vector T and once for the machine-cycle vector M.
// Control priority: CLEAR > zero > hold > load0 > adv.
module onehot_ring
    import beat_timing_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      CLEAR,
    input  logic                      zero,
    input  logic                      load0,
    input  logic                      adv,
    input  logic                      hold,
    output logic [WIDTH-1:0]          vec,
    output logic [idx_w(WIDTH)-1:0]   idx,
    output logic                      last
);

    // Top bit active: the next advance wraps back to bit 0.
    assign last = vec[WIDTH-1];

    // Ring and index update; the wrap is taken from 'last' so a 1-bit ring simply stays put.
    always_ff @(posedge clk) begin
        if (CLEAR || zero) begin
            vec <= '0;
            idx <= '0;
        end else if (!hold) begin
            if (load0 || (adv && last)) begin
                vec <= WIDTH'(1);
                idx <= '0;
            end else if (adv) begin
                vec <= vec << 1;
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/beat_timing_gen.sv
// Beat (T) and machine-cycle (M) timing generator with start/halt,
// wait-state hold, early cycle/instruction termination.
// Optional single-instruction stepping: define BEAT_TIMING_GEN_STEP_EN.
module beat_timing_gen
    import beat_timing_pkg::*;
#(
    parameter int N_BEATS = BEATS_DEFAULT,
    parameter int N_MCYC  = MCYC_DEFAULT
) (
    input  logic                        clk,
    input  logic                        CLEAR,
    input  logic                        start,
    input  logic                        halt,
    input  logic                        hold,
    input  logic                        beat_end,
    input  logic                        instr_end,
    input  logic                        step,
    output logic [N_BEATS-1:0]          T,
    output logic [N_MCYC-1:0]           M,
    output logic [idx_w(N_BEATS)-1:0]   beat_idx,
    output logic [idx_w(N_MCYC)-1:0]    mcyc_idx,
    output logic                        running,
    output logic                        instr_start
);

    state_t state;
    logic   t_last, m_last;
    logic   go, step_go, boundary, stop_bnd;
    logic   t_zero, t_load0, t_adv;
    logic   m_zero, m_load0, m_adv;
    logic   rhold;

`ifdef BEAT_TIMING_GEN_STEP_EN
    logic   step_pending;
`else
    logic   unused_step;
    assign unused_step = step;
`endif

    // Priority decode of the run controls into ring commands.
    always_comb begin
        step_go  = 1'b0;
        stop_bnd = 1'b0;
        t_zero   = 1'b0;
        t_load0  = 1'b0;
        t_adv    = 1'b0;
        m_zero   = 1'b0;
        m_load0  = 1'b0;
        m_adv    = 1'b0;
        rhold    = 1'b0;
        // A natural wrap out of the last beat of the last cycle (beat_end there included) or any instr_end.
        boundary = instr_end || (t_last && m_last);
`ifdef BEAT_TIMING_GEN_STEP_EN
        step_go  = (state == HALTED) && step;
        stop_bnd = step_pending && boundary;
`endif
        go = (state != RUN) && (start || step_go);
        if (state != RUN) begin
            t_load0 = go;
            m_load0 = go;
            t_zero  = !go;
            m_zero  = !go;
        end else if (halt) begin
            t_zero = 1'b1;
            m_zero = 1'b1;
        end else if (hold) begin
            rhold = 1'b1;
        end else if (stop_bnd) begin
            t_zero = 1'b1;
            m_zero = 1'b1;
        end else if (instr_end) begin
            t_load0 = 1'b1;
            m_load0 = 1'b1;
        end else if (beat_end || t_last) begin
            t_load0 = 1'b1;
            m_adv   = 1'b1;
        end else begin
            t_adv = 1'b1;
        end
    end

    // Run-state FSM with registered running flag and step bookkeeping.
    always_ff @(posedge clk) begin
        if (CLEAR) begin
            state   <= IDLE;
            running <= 1'b0;
`ifdef BEAT_TIMING_GEN_STEP_EN
            step_pending <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (go) begin
                        state   <= RUN;
                        running <= 1'b1;
`ifdef BEAT_TIMING_GEN_STEP_EN
                        step_pending <= step_go;
`endif
                    end
                end
                RUN: begin
                    if (halt || (!hold && stop_bnd)) begin
                        state   <= HALTED;
                        running <= 1'b0;
`ifdef BEAT_TIMING_GEN_STEP_EN
                        step_pending <= 1'b0;
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    onehot_ring #(.WIDTH(N_BEATS)) u_t (
        .clk(clk), .CLEAR(CLEAR), .zero(t_zero), .load0(t_load0),
        .adv(t_adv), .hold(rhold), .vec(T), .idx(beat_idx), .last(t_last)
    );

    onehot_ring #(.WIDTH(N_MCYC)) u_m (
        .clk(clk), .CLEAR(CLEAR), .zero(m_zero), .load0(m_load0),
        .adv(m_adv), .hold(rhold), .vec(M), .idx(mcyc_idx), .last(m_last)
    );

    assign instr_start = T[0] & M[0] & running;

endmodule

// File: tb/tb_beat_timing_gen.sv
// Self-checking bench for beat_timing_gen (N_BEATS=8, N_MCYC=4).
// A beat/cycle-number model is updated on every edge and compared each cycle;
// directed literal checks pin the model to the expected sequences.
module tb_beat_timing_gen;

    localparam int NB = 8;
    localparam int NM = 4;
`ifdef BEAT_TIMING_GEN_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          CLEAR, start, halt, hold, beat_end, instr_end, step;
    logic [NB-1:0] T;
    logic [NM-1:0] M;
    logic [2:0]    beat_idx;
    logic [1:0]    mcyc_idx;
    logic          running, instr_start;

    beat_timing_gen #(.N_BEATS(NB), .N_MCYC(NM)) dut (
        .clk(clk), .CLEAR(CLEAR), .start(start), .halt(halt), .hold(hold),
        .beat_end(beat_end), .instr_end(instr_end), .step(step),
        .T(T), .M(M), .beat_idx(beat_idx), .mcyc_idx(mcyc_idx),
        .running(running), .instr_start(instr_start)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: st 0=idle 1=run 2=halted, b = beat number, m = machine cycle number.
    int st = 0, b = 0, m = 0, pend = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_upd(input bit c, s, h, ho, be, ie, sp);
        bool_bnd: begin
            bit bnd;
            if (c) begin
                st = 0; pend = 0; b = 0; m = 0;
            end else if (st != 1) begin
                bit sgo;
                sgo = STEP_EN && (st == 2) && sp;
                if (s || sgo) begin
                    st = 1; b = 0; m = 0;
                    pend = sgo ? 1 : 0;
                end
            end else if (h) begin
                st = 2; pend = 0;
            end else if (!ho) begin
                bnd = ie || (b == NB-1 && m == NM-1);
                if (ie) begin
                    b = 0; m = 0;
                end else if (be || b == NB-1) begin
                    b = 0; m = (m + 1) % NM;
                end else begin
                    b = b + 1;
                end
                if (pend != 0 && bnd) begin
                    st = 2; pend = 0;
                end
            end
        end
    endtask

    task automatic compare();
        bit r;
        r = (st == 1);
        chk("T",           32'(T),           r ? (32'd1 << b) : 32'd0);
        chk("M",           32'(M),           r ? (32'd1 << m) : 32'd0);
        chk("beat_idx",    32'(beat_idx),    r ? 32'(b) : 32'd0);
        chk("mcyc_idx",    32'(mcyc_idx),    r ? 32'(m) : 32'd0);
        chk("running",     32'(running),     32'(r));
        chk("instr_start", 32'(instr_start), 32'(r && b == 0 && m == 0));
    endtask

    task automatic cyc(input bit c, s, h, ho, be, ie, sp);
        CLEAR = c; start = s; halt = h; hold = ho;
        beat_end = be; instr_end = ie; step = sp;
        @(posedge clk);
        model_upd(c, s, h, ho, be, ie, sp);
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        CLEAR = 1; start = 0; halt = 0; hold = 0;
        beat_end = 0; instr_end = 0; step = 0;

        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_T", 32'(T), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        idle(2);
        chk("idle_T", 32'(T), 32'h0);

        // Walk of one instruction.
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("start_T", 32'(T), 32'h01);
        chk("start_M", 32'(M), 32'h1);
        chk("start_is", 32'(instr_start), 32'h1);
        idle(7);
        chk("walk_T80", 32'(T), 32'h80);
        chk("walk_bidx", 32'(beat_idx), 32'd7);
        idle(1);
        chk("wrap_T", 32'(T), 32'h01);
        chk("wrap_M", 32'(M), 32'h2);
        idle(24);
        chk("mwrap_T", 32'(T), 32'h01);
        chk("mwrap_M", 32'(M), 32'h1);

        // Wait-state hold.
        idle(3);
        chk("pre_hold_T", 32'(T), 32'h08);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0, 0, 0);
            chk("hold_T", 32'(T), 32'h08);
        end
        idle(1);
        chk("post_hold_T", 32'(T), 32'h10);

        // Early cycle/instruction termination from T=04, M=2.
        cyc(0, 0, 0, 0, 0, 1, 0);
        idle(10);
        chk("pre_be_T", 32'(T), 32'h04);
        chk("pre_be_M", 32'(M), 32'h2);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("be_T", 32'(T), 32'h01);
        chk("be_M", 32'(M), 32'h4);
        cyc(0, 0, 0, 0, 0, 1, 0);
        idle(10);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("ie_T", 32'(T), 32'h01);
        chk("ie_M", 32'(M), 32'h1);
        chk("ie_is", 32'(instr_start), 32'h1);
        idle(10);
        cyc(0, 0, 0, 0, 1, 1, 0);
        chk("both_M", 32'(M), 32'h1);

        // Halt then restart.
        idle(5);
        chk("pre_halt_T", 32'(T), 32'h20);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("halt_T", 32'(T), 32'h0);
        chk("halt_M", 32'(M), 32'h0);
        chk("halt_running", 32'(running), 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("restart_T", 32'(T), 32'h01);
        chk("restart_M", 32'(M), 32'h1);

        // CLEAR overrides start and hold.
        idle(6);
        chk("pre_clr_T", 32'(T), 32'h40);
        cyc(1, 1, 0, 1, 0, 0, 0);
        chk("clr_T", 32'(T), 32'h0);
        chk("clr_running", 32'(running), 32'h0);

        // Single-instruction step from HALTED.
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        n = running ? 1 : 0;
        while (running && n < 200) begin
            idle(1);
            if (running) n++;
        end
        chk("step_run_cycles", 32'(n), STEP_EN ? 32'd32 : 32'd0);
        chk("step_end_T", 32'(T), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(99) < 1),
                ($urandom_range(99) < 20),
                ($urandom_range(99) < 3),
                ($urandom_range(99) < 15),
                ($urandom_range(99) < 6),
                ($urandom_range(99) < 4),
                ($urandom_range(99) < 10));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beat_timing_gen.md
# beat_timing_gen

Parametrised beat and machine-cycle timing generator for the model computer's control unit. It produces one-hot beat signals T and one-hot machine-cycle signals M, which step the microoperation sequencer. It adds start/halt control, wait-state hold, early cycle and instruction termination, and optional single-instruction stepping, none of which the fixed 8-beat ring provides. It sits between the front-panel/run logic and the control-signal decoder.

## Interface
- N_BEATS, 8, beats per machine cycle (2..32)
- N_MCYC, 4, machine cycles per instruction (1..8)
- clk  in  1  system clock, all state on rising edge
- CLEAR  in  1  synchronous, active-high reset
- start  in  1  leave IDLE/HALTED and begin at T[0], M[0]
- halt  in  1  stop at end of current beat (HLT decoded or panel stop)
- hold  in  1  wait state; freeze T, M, and state while in RUN
- beat_end  in  1  terminate the current machine cycle after this beat
- instr_end  in  1  terminate the current instruction after this beat
- step  in  1  single-instruction step request (used only with the macro)
- T  out  N_BEATS  one-hot beat; all-zero when not running
- M  out  N_MCYC  one-hot machine cycle; all-zero when not running
- beat_idx  out  max(1,$clog2(N_BEATS))  binary index of the active T bit
- mcyc_idx  out  max(1,$clog2(N_MCYC))  binary index of the active M bit
- running  out  1  high in RUN
- instr_start  out  1  high while T[0]&M[0]&running

## Operation
- States: IDLE, RUN, HALTED. CLEAR forces IDLE, T=0, M=0, indices=0, running=0, step_pending=0.
- IDLE/HALTED with start=1: next state RUN, T=1, M=1.
- IDLE/HALTED with start=0: outputs stay zero. halt, hold, beat_end, and instr_end are ignored.
- RUN, per-cycle priority (highest first): halt > hold > instr_end > beat_end > normal advance.
  - halt: next state HALTED, T=M=0.
  - hold: all registers keep their values.
  - instr_end: T=1, M=1.
  - beat_end: T=1, M rotates left; M[N_MCYC-1] wraps to M[0].
  - normal advance: T rotates left. When T[N_BEATS-1] is active, T wraps to T[0] and M rotates as for beat_end.
- start in RUN is ignored.
- beat_end on the last beat is equivalent to a normal wrap.
- With N_MCYC=1, M stays at 1 while in RUN.
- Indices always track the one-hot vectors. The one-hot vectors are authoritative.
- T and M are never multi-hot. An illegal pattern is unreachable; do not add recovery logic.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- start sampled at edge k gives T[0]/M[0]/running visible after edge k, so instr_start is high in cycle k+1.
- halt sampled at edge k gives zero outputs after edge k.
- hold has zero-latency freeze: the beat active during hold is the beat that resumes.
- CLEAR in mid-instruction takes effect at the next edge and overrides every other input.

## Configuration
- BEAT_TIMING_GEN_STEP_EN defined:
  - In HALTED, step=1 sets step_pending and enters RUN at T[0]/M[0].
  - At the next instruction boundary, the block enters HALTED instead of starting T[0]/M[0]. An instruction boundary is a natural wrap from the last beat of M[N_MCYC-1], or any instr_end.
  - step_pending clears on that transition.
  - start while step_pending has no effect.
  - halt during a step enters HALTED and clears step_pending.
- BEAT_TIMING_GEN_STEP_EN undefined: the step port is present but ignored, step_pending does not exist, and the block behaves as the non-step rules above.

## Structure
- Shared package beat_timing_pkg:
  - state enum (IDLE, RUN, HALTED)
  - default-parameter constants BEATS_DEFAULT=8 and MCYC_DEFAULT=4
  - index-width helper function
- Sub-module onehot_ring, instantiated once for T and once for M:
  - parameter WIDTH
  - inputs clk, CLEAR, zero, load0, adv, hold
  - outputs vec, idx, and last (top bit active)
- Top level holds the FSM, priority decode, and step_pending.

## Test plan
- Reset then start pulse, N_BEATS=8, N_MCYC=4 → T walks 01,02,..,80 then 01 with M 1→2; M 8 wraps to 1 after 32 cycles.
- RUN at T=08, hold high 3 cycles → T stays 08 for 3 cycles, then 10.
- T=04/M=2 with beat_end → next T=01, M=4. T=04/M=2 with instr_end → next T=01, M=1 and instr_start=1. Both asserted together → instr_end wins.
- halt at T=20 → T=M=0 and running=0 next cycle. start → T=01, M=1.
- CLEAR asserted together with start and with hold at T=40 → next cycle IDLE with all outputs 0.
- With BEAT_TIMING_GEN_STEP_EN, N_BEATS=4, N_MCYC=2: step from HALTED → exactly 8 running cycles, then HALTED with T=M=0.
